// File: rtl/fp_pkg.sv
// Shared FP32 constants and types for the float <-> integer conversion path.
package fp_pkg;

  localparam int unsigned EXP_W         = 8;
  localparam int unsigned MANT_W        = 23;
  localparam int unsigned EXP_BIAS      = 127;
  localparam int unsigned EXP_INT_LIMIT = 158;
  localparam logic [31:0] INT_MAX       = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StDone
  } conv_state_t;

  typedef enum logic [2:0] {
    ClsNan,
    ClsInf,
    ClsBig,
    ClsZero,
    ClsRshift,
    ClsLshift
  } fp_class_t;

  function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] mag);
    return neg ? (~mag + 32'd1) : mag;
  endfunction

endpackage

// File: rtl/fp32_classify.sv
// Combinational classification of an FP32 word for integer conversion,
// plus the shift distance needed to align the significand to bit 0.
module fp32_classify
  import fp_pkg::*;
(
  input  logic              s_i,
  input  logic [EXP_W-1:0]  e_i,
  input  logic [MANT_W-1:0] m_i,
  output fp_class_t         cls_o,
  output logic [4:0]        amt_o,
  output logic              exact_min_o
);

  localparam logic [EXP_W-1:0] ExpMax   = '1;
  localparam logic [EXP_W-1:0] ExpLimit = EXP_W'(EXP_INT_LIMIT);
  localparam logic [EXP_W-1:0] ExpBias  = EXP_W'(EXP_BIAS);
  // Exponent at which the integer point sits just below the LSB of the significand.
  localparam logic [EXP_W-1:0] ExpPoint = EXP_W'(EXP_BIAS + MANT_W);

  always_comb begin
    cls_o = ClsZero;
    amt_o = '0;
    if (e_i == ExpMax) begin
      cls_o = (m_i != '0) ? ClsNan : ClsInf;
    end else if (e_i >= ExpLimit) begin
      cls_o = ClsBig;
    end else if (e_i < ExpBias) begin
      cls_o = ClsZero;
    end else if (e_i <= ExpPoint) begin
      cls_o = ClsRshift;
      amt_o = 5'(ExpPoint - e_i);
    end else begin
      cls_o = ClsLshift;
      amt_o = 5'(e_i - ExpPoint);
    end
  end

  // -2^31 is the only value at or above the limit that still fits.
  assign exact_min_o = s_i && (e_i == ExpLimit) && (m_i == '0);

endmodule

// File: rtl/fp32_to_int.sv
// Iterative FP32 -> int32 converter, truncating toward zero, shifting STEP
// bits per cycle with valid/ready handshakes on both sides.
module fp32_to_int
  import fp_pkg::*;
#(
  parameter int unsigned STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_ovf,
  output logic        out_inexact
);

  localparam logic [4:0] StepAmt = 5'(STEP);

  conv_state_t state_q, state_d;
  logic [31:0] mag_q, mag_d;
  logic [4:0]  rem_q, rem_d;
  logic        left_q, left_d;
  logic        sign_q, sign_d;
  logic        sticky_q, sticky_d;
  logic [31:0] data_q, data_d;
  logic        ovf_q, ovf_d;
  logic        inexact_q, inexact_d;

  fp_class_t   cls;
  logic [4:0]  amt;
  logic        exact_min;
  logic [31:0] sig_in;
  logic [4:0]  sh;
  logic [31:0] mask;
  logic [31:0] mag_shift;

  fp32_classify u_classify (
    .s_i         (in_data[31]),
    .e_i         (in_data[30:23]),
    .m_i         (in_data[22:0]),
    .cls_o       (cls),
    .amt_o       (amt),
    .exact_min_o (exact_min)
  );

  assign sig_in    = {8'd0, in_data[30:23] != 8'd0, in_data[22:0]};
  assign sh        = (rem_q < StepAmt) ? rem_q : StepAmt;
  assign mask      = (32'd1 << sh) - 32'd1;
  assign mag_shift = left_q ? (mag_q << sh) : (mag_q >> sh);

  always_comb begin
    state_d   = state_q;
    mag_d     = mag_q;
    rem_d     = rem_q;
    left_d    = left_q;
    sign_d    = sign_q;
    sticky_d  = sticky_q;
    data_d    = data_q;
    ovf_d     = ovf_q;
    inexact_d = inexact_q;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sign_d    = in_data[31];
          mag_d     = sig_in;
          rem_d     = amt;
          left_d    = (cls == ClsLshift);
          sticky_d  = 1'b0;
          ovf_d     = 1'b0;
          inexact_d = 1'b0;
          state_d   = StDone;
          unique case (cls)
            ClsNan: begin
              data_d = INT_MAX;
              ovf_d  = 1'b1;
            end
            ClsInf, ClsBig: begin
              data_d = in_data[31] ? INT_MIN : INT_MAX;
              ovf_d  = !exact_min;
            end
            ClsZero: begin
              data_d    = '0;
              inexact_d = (in_data[30:0] != 31'd0);
            end
            ClsRshift, ClsLshift: begin
              if (amt == 5'd0) begin
                data_d = apply_sign(in_data[31], sig_in);
              end else begin
                state_d = StShift;
              end
            end
            default: ;
          endcase
        end
      end
      StShift: begin
        mag_d = mag_shift;
        rem_d = rem_q - sh;
        if (!left_q) begin
          sticky_d = sticky_q | (|(mag_q & mask));
        end
        if (rem_d == 5'd0) begin
          data_d    = apply_sign(sign_q, mag_shift);
          inexact_d = sticky_d;
          ovf_d     = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      mag_q     <= '0;
      rem_q     <= '0;
      left_q    <= 1'b0;
      sign_q    <= 1'b0;
      sticky_q  <= 1'b0;
      data_q    <= '0;
      ovf_q     <= 1'b0;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mag_q     <= mag_d;
      rem_q     <= rem_d;
      left_q    <= left_d;
      sign_q    <= sign_d;
      sticky_q  <= sticky_d;
      data_q    <= data_d;
      ovf_q     <= ovf_d;
      inexact_q <= inexact_d;
    end
  end

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign out_data    = data_q;
  assign out_ovf     = ovf_q;
  assign out_inexact = inexact_q;

endmodule

// File: tb/tb_fp32_to_int.sv
// Bench for fp32_to_int: STEP=1 and STEP=4 instances, directed cases plus
// random words checked against a value-range reference model.
module tb_fp32_to_int;

  logic        clk;
  logic        rst_n;
  logic        in_valid    [2];
  logic        in_ready    [2];
  logic [31:0] in_data     [2];
  logic        out_valid   [2];
  logic        out_ready   [2];
  logic [31:0] out_data    [2];
  logic        out_ovf     [2];
  logic        out_inexact [2];

  int checks = 0;
  int errors = 0;

  fp32_to_int #(.STEP(1)) u_dut1 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid[0]),
    .in_ready    (in_ready[0]),
    .in_data     (in_data[0]),
    .out_valid   (out_valid[0]),
    .out_ready   (out_ready[0]),
    .out_data    (out_data[0]),
    .out_ovf     (out_ovf[0]),
    .out_inexact (out_inexact[0])
  );

  fp32_to_int #(.STEP(4)) u_dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid[1]),
    .in_ready    (in_ready[1]),
    .in_data     (in_data[1]),
    .out_valid   (out_valid[1]),
    .out_ready   (out_ready[1]),
    .out_data    (out_data[1]),
    .out_ovf     (out_ovf[1]),
    .out_inexact (out_inexact[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: truncated magnitude of the real value, then range check.
  function automatic void ref_model(input logic [31:0] w, input int step,
                                    output logic [31:0] d, output logic ovf,
                                    output logic inx, output int lat);
    logic s;
    int e, amt, shift;
    longint unsigned sig, mag, lim;
    bit frac, huge;
    s = w[31];
    e = int'(w[30:23]);
    sig = (e != 0) ? (64'd8388608 + 64'(w[22:0])) : 64'(w[22:0]);
    lat = 1;
    if (e >= 127 && e <= 157) begin
      amt = (e > 150) ? e - 150 : 150 - e;
      lat = 1 + (amt + step - 1) / step;
    end
    if (e == 255) begin
      d = (w[22:0] != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
      ovf = 1'b1;
      inx = 1'b0;
      return;
    end
    huge = 1'b0;
    frac = 1'b0;
    mag = 0;
    if (e >= 190) begin
      huge = 1'b1;
    end else if (e >= 150) begin
      mag = sig << (e - 150);
    end else begin
      shift = 150 - e;
      if (shift >= 64) begin
        frac = (sig != 0);
      end else begin
        mag  = sig / (64'd1 << shift);
        frac = (sig % (64'd1 << shift)) != 0;
      end
    end
    lim = s ? 64'd2147483648 : 64'd2147483647;
    if (huge || mag > lim) begin
      d = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      ovf = 1'b1;
      inx = 1'b0;
    end else begin
      d = s ? 32'(-mag) : 32'(mag);
      ovf = 1'b0;
      inx = frac;
    end
  endfunction

  task automatic xfer(input int k, input logic [31:0] w, input int hold);
    logic [31:0] ed;
    logic eo, ei;
    int el, cyc;
    ref_model(w, (k == 0) ? 1 : 4, ed, eo, ei, el);
    cyc = 0;
    @(negedge clk);
    while (!in_ready[k] && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("in_ready[%0d] %h", k, w), 32'(in_ready[k]), 32'd1);
    out_ready[k] = (hold == 0);
    in_valid[k]  = 1'b1;
    in_data[k]   = w;
    @(negedge clk);
    in_valid[k] = 1'b0;
    in_data[k]  = $urandom;
    cyc = 1;
    while (!out_valid[k] && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("latency[%0d] %h", k, w), 32'(cyc), 32'(el));
    chk($sformatf("data[%0d] %h", k, w), out_data[k], ed);
    chk($sformatf("ovf[%0d] %h", k, w), 32'(out_ovf[k]), 32'(eo));
    chk($sformatf("inexact[%0d] %h", k, w), 32'(out_inexact[k]), 32'(ei));
    for (int i = 0; i < hold; i++) begin
      in_valid[k] = 1'b1;
      in_data[k]  = 32'h3F80_0000;
      @(negedge clk);
      chk($sformatf("bp valid %0d", i), 32'(out_valid[k]), 32'd1);
      chk($sformatf("bp in_ready %0d", i), 32'(in_ready[k]), 32'd0);
      chk($sformatf("bp data %0d", i), out_data[k], ed);
      chk($sformatf("bp flags %0d", i), {30'd0, out_ovf[k], out_inexact[k]}, {30'd0, eo, ei});
    end
    if (hold > 0) begin
      in_valid[k]  = 1'b0;
      out_ready[k] = 1'b1;
      @(negedge clk);
      chk("bp release valid", 32'(out_valid[k]), 32'd0);
      chk("bp release ready", 32'(in_ready[k]), 32'd1);
    end
  endtask

  initial begin
    logic [31:0] directed [12];
    logic [31:0] w;
    directed = '{32'h3FC0_0000, 32'hC2F6_E979, 32'h4E80_0000, 32'h4F00_0000,
                 32'hCF00_0000, 32'h7FC0_0000, 32'h0000_0001, 32'h8000_0000,
                 32'hFF80_0000, 32'h4EFF_FFFF, 32'hCF00_0001, 32'h4B00_0001};
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid[k]  = 1'b0;
      in_data[k]   = '0;
      out_ready[k] = 1'b1;
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset in_ready", 32'(in_ready[k]), 32'd1);
      chk("reset out_valid", 32'(out_valid[k]), 32'd0);
      chk("reset out_data", out_data[k], 32'd0);
      chk("reset flags", {30'd0, out_ovf[k], out_inexact[k]}, 32'd0);
    end
    rst_n = 1'b1;

    foreach (directed[i]) xfer(0, directed[i], 0);
    xfer(1, 32'hC2F6_E979, 0);
    xfer(1, 32'h3FC0_0000, 0);
    xfer(1, 32'hCF00_0000, 0);

    // Backpressure: hold DONE for 5 cycles with a competing in_valid.
    xfer(0, 32'hC2F6_E979, 5);
    xfer(1, 32'h4E80_0000, 5);

    // Reset mid-SHIFT, then a clean conversion.
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = 32'h3FC0_0000;
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid-shift busy", 32'(in_ready[0]), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort in_ready", 32'(in_ready[0]), 32'd1);
    chk("abort out_valid", 32'(out_valid[0]), 32'd0);
    chk("abort out_data", out_data[0], 32'd0);
    chk("abort flags", {30'd0, out_ovf[0], out_inexact[0]}, 32'd0);
    xfer(0, 32'h4000_0000, 0);

    for (int i = 0; i < 150; i++) begin
      for (int k = 0; k < 2; k++) begin
        w = $urandom;
        if ($urandom_range(0, 3) != 0) w[30:23] = 8'($urandom_range(110, 165));
        if ($urandom_range(0, 7) == 0) w[22:0] = '0;
        xfer(k, w, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
